tagged_regfile_mp: RTL and testbench

Parametrised, multi-ported Tomasulo register file holding the architectural value and producer tag of every register. It has several read ports, one issue (tag-write) port, several CDB broadcast ports with same-cycle read bypass, a global flush that clears all tags, and a registered count of pending registers. It sits between decode/issue and the reservation stations.

---
 rtl/tagged_regfile_mp.sv | 103 ++++++++++
 tb/tb_tagged_regfile_mp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/tagged_regfile_mp.sv
// rtl/tagged_regfile_mp.sv - multi-ported Tomasulo register file with producer tags, CDB bypass and flush
module tagged_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int TAG_W  = 4,
    parameter int NRD    = 4,
    parameter int NBC    = 2,
    parameter int AW     = $clog2(NREG),
    parameter int CW     = $clog2(NREG) + 1
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic [NRD*AW-1:0]     ReadAddr,
    output logic [NRD*DATA_W-1:0] DataOut,
    output logic [NRD*TAG_W-1:0]  LabelOut,
    input  logic                  IssueEn,
    input  logic [AW-1:0]         WriteAddr,
    input  logic [TAG_W-1:0]      WriteLabel,
    input  logic [NBC-1:0]        BCEN,
    input  logic [NBC*TAG_W-1:0]  BClabel,
    input  logic [NBC*DATA_W-1:0] BCdata,
    input  logic                  Flush,
    output logic [CW-1:0]         PendingCnt
);

    logic [DATA_W-1:0] data_q   [1:NREG-1];
    logic [TAG_W-1:0]  tag_q    [1:NREG-1];
    logic [DATA_W-1:0] data_nxt [1:NREG-1];
    logic [TAG_W-1:0]  tag_nxt  [1:NREG-1];
    logic [DATA_W:0]   hit      [1:NREG-1];
    logic [CW-1:0]     cnt_nxt;

    // {match, data}; scanning downward lets the lowest-indexed port win; tag 0 never matches
    function automatic logic [DATA_W:0] bc_lookup(input logic [TAG_W-1:0] t,
                                                  input logic [NBC-1:0] en,
                                                  input logic [NBC*TAG_W-1:0] lab,
                                                  input logic [NBC*DATA_W-1:0] dat);
        logic [DATA_W:0] res;
        res = '0;
        for (int k = NBC - 1; k >= 0; k--) begin
            if (t != '0 && en[k] && lab[k*TAG_W +: TAG_W] == t)
                res = {1'b1, dat[k*DATA_W +: DATA_W]};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 1; i < NREG; i++)
            hit[i] = bc_lookup(tag_q[i], BCEN, BClabel, BCdata);
    end

    always_comb begin
        DataOut  = '0;
        LabelOut = '0;
        for (int r = 0; r < NRD; r++) begin
            if (ReadAddr[r*AW +: AW] != '0) begin
                if (hit[ReadAddr[r*AW +: AW]][DATA_W]) begin
                    DataOut[r*DATA_W +: DATA_W] = hit[ReadAddr[r*AW +: AW]][DATA_W-1:0];
                end else begin
                    DataOut[r*DATA_W +: DATA_W] = data_q[ReadAddr[r*AW +: AW]];
                    LabelOut[r*TAG_W +: TAG_W]  = tag_q[ReadAddr[r*AW +: AW]];
                end
            end
        end
    end

    // A same-cycle issue to a register overrides the tag clear from its completing broadcast
    always_comb begin
        cnt_nxt = '0;
        for (int i = 1; i < NREG; i++) begin
            data_nxt[i] = data_q[i];
            tag_nxt[i]  = tag_q[i];
            if (Flush) begin
                tag_nxt[i] = '0;
            end else begin
                if (hit[i][DATA_W]) begin
                    data_nxt[i] = hit[i][DATA_W-1:0];
                    tag_nxt[i]  = '0;
                end
                if (IssueEn && WriteAddr == AW'(i))
                    tag_nxt[i] = WriteLabel;
            end
            cnt_nxt = cnt_nxt + CW'(tag_nxt[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            for (int i = 1; i < NREG; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            PendingCnt <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                data_q[i] <= data_nxt[i];
                tag_q[i]  <= tag_nxt[i];
            end
            PendingCnt <= Flush ? '0 : cnt_nxt;
        end
    end

endmodule

// File: tb/tb_tagged_regfile_mp.sv
// tb/tb_tagged_regfile_mp.sv - scoreboard bench for tagged_regfile_mp against an array reference model
module tb_tagged_regfile_mp;

    localparam int DATA_W = 32;
    localparam int NREG   = 32;
    localparam int TAG_W  = 4;
    localparam int NRD    = 4;
    localparam int NBC    = 2;
    localparam int AW     = 5;
    localparam int CW     = 6;

    logic                  clk = 1'b0;
    logic                  RST;
    logic [NRD*AW-1:0]     ReadAddr;
    logic [NRD*DATA_W-1:0] DataOut;
    logic [NRD*TAG_W-1:0]  LabelOut;
    logic                  IssueEn;
    logic [AW-1:0]         WriteAddr;
    logic [TAG_W-1:0]      WriteLabel;
    logic [NBC-1:0]        BCEN;
    logic [NBC*TAG_W-1:0]  BClabel;
    logic [NBC*DATA_W-1:0] BCdata;
    logic                  Flush;
    logic [CW-1:0]         PendingCnt;

    tagged_regfile_mp #(
        .DATA_W(DATA_W), .NREG(NREG), .TAG_W(TAG_W), .NRD(NRD), .NBC(NBC)
    ) dut (
        .clk(clk), .RST(RST), .ReadAddr(ReadAddr), .DataOut(DataOut), .LabelOut(LabelOut),
        .IssueEn(IssueEn), .WriteAddr(WriteAddr), .WriteLabel(WriteLabel),
        .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .Flush(Flush), .PendingCnt(PendingCnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NRD*DATA_W-1:0] d;
        logic [NRD*TAG_W-1:0]  t;
        logic [CW-1:0]         c;
        string                 name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [DATA_W-1:0] m_data [NREG];
    logic [TAG_W-1:0]  m_tag  [NREG];
    string             cur_name;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Returns the broadcast port whose tag matches t (lowest index), or -1
    function automatic int bc_port(input logic [TAG_W-1:0] t);
        if (t == 0) return -1;
        for (int k = 0; k < NBC; k++)
            if (BCEN[k] && BClabel[k*TAG_W +: TAG_W] == t) return k;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_data[i] = '0;
            m_tag[i]  = '0;
        end
    endtask

    task automatic push_expect();
        exp_t e;
        int   a, k, cnt;
        e.d = '0;
        e.t = '0;
        for (int r = 0; r < NRD; r++) begin
            a = int'(ReadAddr[r*AW +: AW]);
            if (a != 0) begin
                k = bc_port(m_tag[a]);
                if (k >= 0) begin
                    e.d[r*DATA_W +: DATA_W] = BCdata[k*DATA_W +: DATA_W];
                end else begin
                    e.d[r*DATA_W +: DATA_W] = m_data[a];
                    e.t[r*TAG_W +: TAG_W]   = m_tag[a];
                end
            end
        end
        cnt = 0;
        for (int i = 1; i < NREG; i++) if (m_tag[i] != 0) cnt++;
        e.c    = CW'(cnt);
        e.name = cur_name;
        exp_q.push_back(e);
    endtask

    task automatic model_update();
        logic [DATA_W-1:0] nd [NREG];
        logic [TAG_W-1:0]  nt [NREG];
        int k;
        for (int i = 1; i < NREG; i++) begin
            nd[i] = m_data[i];
            nt[i] = m_tag[i];
            if (RST) begin
                nd[i] = '0;
                nt[i] = '0;
            end else if (Flush) begin
                nt[i] = '0;
            end else begin
                k = bc_port(m_tag[i]);
                if (k >= 0) begin
                    nd[i] = BCdata[k*DATA_W +: DATA_W];
                    nt[i] = '0;
                end
                if (IssueEn && int'(WriteAddr) == i) nt[i] = WriteLabel;
            end
        end
        for (int i = 1; i < NREG; i++) begin
            m_data[i] = nd[i];
            m_tag[i]  = nt[i];
        end
    endtask

    task automatic idle();
        RST = 0; IssueEn = 0; WriteAddr = '0; WriteLabel = '0;
        BCEN = '0; BClabel = '0; BCdata = '0; Flush = 0;
    endtask

    task automatic rd(input int a0, input int a1, input int a2, input int a3);
        ReadAddr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    task automatic issue(input int a, input int l);
        IssueEn = 1; WriteAddr = AW'(a); WriteLabel = TAG_W'(l);
    endtask

    task automatic bc(input int p, input int l, input logic [DATA_W-1:0] d);
        BCEN[p] = 1'b1;
        BClabel[p*TAG_W +: TAG_W] = TAG_W'(l);
        BCdata[p*DATA_W +: DATA_W] = d;
    endtask

    // One clock: record expectations for the current inputs, then advance model with the DUT
    task automatic cycle(input string name);
        cur_name = name;
        push_expect();
        @(posedge clk);
        model_update();
        #1;
        idle();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, "_data"},  128'(DataOut),    128'(e.d));
                check({e.name, "_label"}, 128'(LabelOut),   128'(e.t));
                check({e.name, "_cnt"},   128'(PendingCnt), 128'(e.c));
            end
        end
    end

    initial begin : driver
        idle();
        rd(0, 0, 0, 0);
        RST = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        RST = 0;

        for (int g = 0; g < NREG / NRD; g++) begin
            rd(4*g, 4*g+1, 4*g+2, 4*g+3);
            cycle("reset_read");
        end
        rd(0, 0, 0, 0); issue(0, 5); cycle("issue_r0");
        rd(0, 0, 0, 0); cycle("r0_after_issue");

        rd(3, 0, 0, 0); issue(3, 7); cycle("issue_r3");
        rd(3, 3, 0, 0); cycle("r3_pending");
        rd(3, 0, 3, 0); bc(1, 7, 32'hDEADBEEF); cycle("r3_bypass");
        rd(3, 0, 0, 0); cycle("r3_stored");

        issue(5, 2); cycle("issue_r5");
        rd(5, 0, 0, 0); bc(0, 2, 32'h11); issue(5, 9); cycle("waw_r5");
        rd(5, 0, 0, 0); cycle("waw_r5_after");

        issue(1, 4); cycle("issue_r1");
        issue(2, 4); cycle("issue_r2");
        issue(6, 3); cycle("issue_r6");
        rd(1, 2, 6, 5); bc(0, 4, 32'hA); bc(1, 3, 32'hB); cycle("multi_bc");
        rd(1, 2, 6, 5); cycle("multi_bc_after");

        issue(7, 4); cycle("issue_r7");
        rd(7, 0, 0, 0); bc(0, 4, 32'h1); bc(1, 4, 32'h2); cycle("dup_tag");
        rd(7, 5, 0, 0); cycle("dup_tag_after");
        rd(7, 5, 0, 0); bc(0, 0, 32'h55); bc(1, 0, 32'h66); cycle("tag0_bc");
        rd(7, 5, 0, 0); cycle("tag0_after");

        for (int i = 10; i < 20; i++) begin
            issue(i, 1 + (i % 15));
            cycle("issue_many");
        end
        rd(8, 10, 11, 5); issue(8, 6); bc(0, 11, 32'hBAD0BAD0); Flush = 1; cycle("flush");
        for (int g = 0; g < NREG / NRD; g++) begin
            rd(4*g, 4*g+1, 4*g+2, 4*g+3);
            cycle("flush_after");
        end

        for (int n = 0; n < 1500; n++) begin
            ReadAddr = NRD*AW'($urandom);
            if ($urandom_range(0, 3) != 0) issue($urandom_range(0, NREG-1), $urandom_range(0, 15));
            for (int p = 0; p < NBC; p++)
                if ($urandom_range(0, 1) == 1) bc(p, $urandom_range(0, 15), $urandom);
            Flush = ($urandom_range(0, 39) == 0);
            RST   = ($urandom_range(0, 149) == 0);
            cycle("random");
        end

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
